plic_apb_regs_n: RTL and testbench

Parametrised APB register file and timeout engine for the PLIC, supporting up to 32 interrupt sources with configurable priority and timeout widths. It captures raw interrupt sources into sticky pending bits (edge or level per source), applies enables and priorities for the downstream arbiter, and runs a pending-interrupt timeout counter. Optional APB error reporting covers unmapped addresses and writes to read-only registers.

---
 rtl/plic_pkg.sv | 31 +++
 rtl/plic_tmo_ctr.sv | 59 +++++
 rtl/plic_apb_regs_n.sv | 164 ++++++++++++++++
 tb/tb_plic_apb_regs_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - register offsets, bit indices and timeout state type for the PLIC register block
package plic_pkg;

  localparam logic [7:0] OFF_SYSCR = 8'h00;
  localparam logic [7:0] OFF_IER   = 8'h04;
  localparam logic [7:0] OFF_ISCR  = 8'h08;
  localparam logic [7:0] OFF_ISR   = 8'h0C;
  localparam logic [7:0] OFF_TMO   = 8'h10;
  localparam logic [7:0] OFF_SSR   = 8'h14;
  localparam logic [7:0] OFF_TMC   = 8'h18;
  localparam logic [7:0] OFF_IPR0  = 8'h20;

  localparam int SYSCR_GEN       = 0;
  localparam int SYSCR_SLVERR_EN = 1;
  localparam int SYSCR_TMO_EN    = 2;

  localparam int SSR_TMO    = 0;
  localparam int SSR_APBERR = 1;

  typedef enum logic [1:0] {
    TMO_IDLE    = 2'd0,
    TMO_COUNT   = 2'd1,
    TMO_EXPIRED = 2'd2
  } tmo_state_e;

  // Number of IPR words needed to hold 8 priority nibbles each
  function automatic int ipr_words(input int num_irq);
    return (num_irq + 7) / 8;
  endfunction

endpackage

// File: rtl/plic_tmo_ctr.sv
// rtl/plic_tmo_ctr.sv - pending-interrupt timeout FSM, down-counter and expiry pulse
module plic_tmo_ctr
  import plic_pkg::*;
#(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pend,
  input  logic [TMO_W-1:0] reload,
  output logic [TMO_W-1:0] count,
  output logic             expired
);

  tmo_state_e state;

  // Idle tracks the reload value; count runs down while pend is held and fires once at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TMO_IDLE;
      count   <= '1;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        TMO_IDLE: begin
          count <= reload;
          if (en && pend) begin
            state <= TMO_COUNT;
          end
        end
        TMO_COUNT: begin
          if (!en || !pend) begin
            state <= TMO_IDLE;
            count <= reload;
          end else if (count == '0) begin
            state   <= TMO_EXPIRED;
            expired <= 1'b1;
          end else begin
            count <= count - TMO_W'(1);
          end
        end
        TMO_EXPIRED: begin
          count <= '0;
          if (!en || !pend) begin
            state <= TMO_IDLE;
            count <= reload;
          end
        end
        default: begin
          state <= TMO_IDLE;
          count <= reload;
        end
      endcase
    end
  end

endmodule

// File: rtl/plic_apb_regs_n.sv
// rtl/plic_apb_regs_n.sv - PLIC APB register file: decode, sticky pending capture, enables, priorities
module plic_apb_regs_n
  import plic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int PRIO_W  = 3,
  parameter int TMO_W   = 8
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [31:0]               paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic [NUM_IRQ-1:0]        irq_src_i,
  input  logic                      irq_pend_i,
  output logic [NUM_IRQ-1:0]        irq_pend_o,
  output logic [NUM_IRQ*PRIO_W-1:0] prio_o,
  output logic                      tmo_expired_o
);

  localparam int         NUM_IPR = ipr_words(NUM_IRQ);
  localparam logic [7:0] IPR_END = OFF_IPR0 + 8'(4 * NUM_IPR);

  logic [7:0]         off;
  logic [1:0]         ipr_idx;
  logic               acc, wr_stb, rd_stb;
  logic               reg_hit, ipr_hit, err, wr_ok;
  logic [2:0]         syscr;
  logic [NUM_IRQ-1:0] ier, iscr, isr, src_q;
  logic [NUM_IRQ-1:0] isr_set, isr_clr;
  logic [TMO_W-1:0]   tmo, tmc;
  logic [1:0]         ssr, ssr_set, ssr_clr;
  logic [31:0]        rd_val;
  logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
  logic               unused_bits;

  assign off         = paddr[7:0];
  assign ipr_idx     = off[3:2];
  assign unused_bits = ^{paddr[31:8], pwdata};
  assign acc         = psel & penable;
  assign wr_stb      = acc & pwrite;
  assign rd_stb      = acc & ~pwrite;
  assign pready      = 1'b1;

  // Address decode; an unmapped offset or a write to the read-only count is an error
  always_comb begin
    ipr_hit = (off >= OFF_IPR0) && (off < IPR_END) && (off[1:0] == 2'b00);
    case (off)
      OFF_SYSCR, OFF_IER, OFF_ISCR, OFF_ISR,
      OFF_TMO, OFF_SSR, OFF_TMC: reg_hit = 1'b1;
      default:                   reg_hit = 1'b0;
    endcase
    err   = acc & (~(reg_hit | ipr_hit) | (pwrite & (off == OFF_TMC)));
    wr_ok = wr_stb & ~err;
  end

  // Plain read/write control registers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      syscr <= '0;
      ier   <= '0;
      iscr  <= '0;
      tmo   <= '1;
    end else if (wr_ok) begin
      case (off)
        OFF_SYSCR: syscr <= pwdata[2:0];
        OFF_IER:   ier   <= pwdata[NUM_IRQ-1:0];
        OFF_ISCR:  iscr  <= pwdata[NUM_IRQ-1:0];
        OFF_TMO:   tmo   <= pwdata[TMO_W-1:0];
        default:   ;
      endcase
    end
  end

  // Priority fields: source k lives in nibble k%8 of IPR word k/8
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        prio_q[k] <= '0;
      end
    end else if (wr_ok && ipr_hit) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        if (int'(ipr_idx) == k / 8) begin
          prio_q[k] <= pwdata[4*(k%8) +: PRIO_W];
        end
      end
    end
  end

  // Set terms for pending and status; a same-cycle set overrides the W1C clear
  always_comb begin
    isr_set = (iscr & irq_src_i & ~src_q) | (~iscr & irq_src_i);
    isr_clr = (wr_ok && off == OFF_ISR) ? pwdata[NUM_IRQ-1:0] : '0;
    ssr_set = '0;
    ssr_set[SSR_TMO]    = tmo_expired_o;
    ssr_set[SSR_APBERR] = err;
    ssr_clr = (wr_ok && off == OFF_SSR) ? pwdata[1:0] : '0;
  end

  // Sticky pending bits, source history for edge detection, and status bits
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      isr   <= '0;
      src_q <= '0;
      ssr   <= '0;
    end else begin
      isr   <= (isr & ~isr_clr) | isr_set;
      src_q <= irq_src_i;
      ssr   <= (ssr & ~ssr_clr) | ssr_set;
    end
  end

  // Read mux; data is driven only during a valid read strobe
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_SYSCR: rd_val[2:0]         = syscr;
      OFF_IER:   rd_val[NUM_IRQ-1:0] = ier;
      OFF_ISCR:  rd_val[NUM_IRQ-1:0] = iscr;
      OFF_ISR:   rd_val[NUM_IRQ-1:0] = isr;
      OFF_TMO:   rd_val[TMO_W-1:0]   = tmo;
      OFF_SSR:   rd_val[1:0]         = ssr;
      OFF_TMC:   rd_val[TMO_W-1:0]   = tmc;
      default: begin
        if (ipr_hit) begin
          for (int k = 0; k < NUM_IRQ; k++) begin
            if (int'(ipr_idx) == k / 8) begin
              rd_val[4*(k%8) +: PRIO_W] = prio_q[k];
            end
          end
        end
      end
    endcase
    prdata  = (rd_stb && !err) ? rd_val : '0;
    pslverr = err & syscr[SYSCR_SLVERR_EN];
  end

  // Downstream arbiter view: enabled pending sources and flattened priorities
  always_comb begin
    irq_pend_o = syscr[SYSCR_GEN] ? (isr & ier) : '0;
    prio_o     = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      prio_o[k*PRIO_W +: PRIO_W] = prio_q[k];
    end
  end

  plic_tmo_ctr #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk     (pclk),
    .rst_n   (preset_n),
    .en      (syscr[SYSCR_TMO_EN]),
    .pend    (irq_pend_i),
    .reload  (tmo),
    .count   (tmc),
    .expired (tmo_expired_o)
  );

endmodule

// File: tb/tb_plic_apb_regs_n.sv
// tb/tb_plic_apb_regs_n.sv - scoreboard bench for plic_apb_regs_n
module tb_plic_apb_regs_n;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  src = '0;
  logic        pend = 1'b0;
  logic [7:0]  irq_pend_o;
  logic [23:0] prio_o;
  logic        tmo_expired_o;

  plic_apb_regs_n #(.NUM_IRQ(8), .PRIO_W(3), .TMO_W(8)) dut (
    .pclk          (pclk),
    .preset_n      (preset_n),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .irq_src_i     (src),
    .irq_pend_i    (pend),
    .irq_pend_o    (irq_pend_o),
    .prio_o        (prio_o),
    .tmo_expired_o (tmo_expired_o)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          kind;
    logic [31:0] d;
    logic        e;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   pulse_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic probe = 1'b0;
  logic do_final = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    exp_t        e;
    logic [31:0] act;
    logic        acte;
    int          p;
    if ((psel && penable) || probe) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (probe) begin
          act  = (e.kind == 1) ? 32'(irq_pend_o) : 32'(prio_o);
          acte = 1'b0;
        end else begin
          act  = prdata;
          acte = pslverr;
        end
        if (act !== e.d || acte !== e.e || (probe && e.kind == 0) || (!probe && e.kind != 0)) begin
          errors++;
          $display("FAIL %s: got data=%h err=%b, expected data=%h err=%b", e.name, act, acte, e.d, e.e);
        end
      end
    end
    if (tmo_expired_o) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL tmo_pulse: unexpected pulse at cycle %0d, expected none", cyc);
      end else begin
        p = pulse_q.pop_front();
        if (p != cyc) begin
          errors++;
          $display("FAIL tmo_pulse: pulse at cycle %0d, expected cycle %0d", cyc, p);
        end
      end
    end
    if (do_final) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      checks++;
      if (pulse_q.size() != 0) begin
        errors++;
        $display("FAIL pulse_drain: %0d pulses missing, expected 0", pulse_q.size());
      end
    end
  end

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err, input string nm);
    sb.push_back('{kind: 0, d: 32'h0, e: exp_err, name: nm});
    @(posedge pclk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {24'h0, a}; pwdata = d;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err, input string nm);
    sb.push_back('{kind: 0, d: exp_d, e: exp_err, name: nm});
    @(posedge pclk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'h0, a};
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [31:0] v, input string nm);
    sb.push_back('{kind: kind, d: v, e: 1'b0, name: nm});
    probe = 1'b1;
    @(negedge pclk); #1 probe = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;

    // reset state
    chk(1, 32'h0, "rst_irq_pend");
    chk(2, 32'h0, "rst_prio");
    apb_rd(8'h00, 32'h0,  1'b0, "rst_syscr");
    apb_rd(8'h04, 32'h0,  1'b0, "rst_ier");
    apb_rd(8'h08, 32'h0,  1'b0, "rst_iscr");
    apb_rd(8'h0C, 32'h0,  1'b0, "rst_isr");
    apb_rd(8'h10, 32'hFF, 1'b0, "rst_tmo");
    apb_rd(8'h14, 32'h0,  1'b0, "rst_ssr");
    apb_rd(8'h18, 32'hFF, 1'b0, "rst_tmc");
    apb_rd(8'h20, 32'h0,  1'b0, "rst_ipr0");
    apb_rd(8'h1C, 32'h0,  1'b0, "unmapped_noerr");
    apb_rd(8'h24, 32'h0,  1'b0, "ipr1_unmapped_noerr");
    apb_rd(8'h14, 32'h2,  1'b0, "ssr_apberr_set");
    apb_wr(8'h14, 32'h2,  1'b0, "ssr_w1c");
    apb_rd(8'h14, 32'h0,  1'b0, "ssr_cleared");

    // edge-triggered source 3
    apb_wr(8'h08, 32'h08, 1'b0, "wr_iscr");
    apb_wr(8'h04, 32'h08, 1'b0, "wr_ier");
    apb_wr(8'h00, 32'h01, 1'b0, "wr_syscr_gen");
    apb_rd(8'h08, 32'h08, 1'b0, "rd_iscr");
    @(posedge pclk); #1 src = 8'h08;
    @(posedge pclk); #1 src = 8'h00;
    chk(1, 32'h08, "edge_irq_pend");
    apb_rd(8'h0C, 32'h08, 1'b0, "edge_isr_set");
    apb_wr(8'h0C, 32'h08, 1'b0, "edge_isr_w1c");
    apb_rd(8'h0C, 32'h00, 1'b0, "edge_isr_clr");
    chk(1, 32'h00, "edge_irq_pend_clr");
    repeat (3) @(posedge pclk);
    #1 apb_rd(8'h0C, 32'h00, 1'b0, "edge_no_reset");

    // level source 1
    apb_wr(8'h04, 32'h0A, 1'b0, "wr_ier_lvl");
    src = 8'h02;
    apb_rd(8'h0C, 32'h02, 1'b0, "lvl_isr_set");
    chk(1, 32'h02, "lvl_irq_pend");
    apb_wr(8'h0C, 32'h02, 1'b0, "lvl_w1c_while_high");
    apb_rd(8'h0C, 32'h02, 1'b0, "lvl_set_wins");
    src = 8'h00;
    apb_wr(8'h0C, 32'h02, 1'b0, "lvl_w1c_low");
    apb_rd(8'h0C, 32'h00, 1'b0, "lvl_isr_clr");
    chk(1, 32'h00, "lvl_irq_pend_clr");

    // priorities
    apb_wr(8'h20, 32'h7654_3210, 1'b0, "wr_ipr0_a");
    apb_rd(8'h20, 32'h7654_3210, 1'b0, "rd_ipr0_a");
    chk(2, 32'h00FA_C688, "prio_a");
    apb_wr(8'h20, 32'h89AB_CDEF, 1'b0, "wr_ipr0_b");
    apb_rd(8'h20, 32'h0123_4567, 1'b0, "rd_ipr0_b_masked");
    chk(2, 32'h0005_3977, "prio_b");

    // timeout expiry, reload 3
    apb_wr(8'h10, 32'h03, 1'b0, "wr_tmo");
    apb_wr(8'h00, 32'h05, 1'b0, "wr_syscr_tmo");
    @(posedge pclk); #1 pend = 1'b1; pulse_q.push_back(cyc + 5);
    repeat (8) @(posedge pclk);
    #1 apb_rd(8'h14, 32'h1, 1'b0, "tmo_ssr_set");
    apb_rd(8'h18, 32'h0, 1'b0, "tmo_tmc_held0");
    pend = 1'b0;
    apb_rd(8'h18, 32'h3, 1'b0, "tmo_tmc_reload");
    apb_wr(8'h14, 32'h1, 1'b0, "tmo_ssr_w1c");
    apb_rd(8'h14, 32'h0, 1'b0, "tmo_ssr_clr");

    // pend drops at count 1: no pulse
    @(posedge pclk); #1 pend = 1'b1;
    repeat (3) @(posedge pclk);
    #1 pend = 1'b0;
    apb_rd(8'h18, 32'h3, 1'b0, "abort_tmc_reload");
    apb_rd(8'h14, 32'h0, 1'b0, "abort_ssr");

    // slave error reporting
    apb_wr(8'h00, 32'h03, 1'b0, "wr_syscr_slverr");
    apb_wr(8'h18, 32'h55, 1'b1, "wr_tmc_err");
    apb_rd(8'h18, 32'h03, 1'b0, "tmc_unchanged");
    apb_rd(8'h14, 32'h02, 1'b0, "ssr_err_set");
    apb_rd(8'h1C, 32'h00, 1'b1, "rd_unmapped_err");
    apb_rd(8'h01, 32'h00, 1'b1, "rd_unaligned_err");
    apb_wr(8'h14, 32'h02, 1'b0, "ssr_err_w1c");
    apb_rd(8'h14, 32'h00, 1'b0, "ssr_err_clr");

    // reset in the middle of a count
    apb_wr(8'h00, 32'h05, 1'b0, "wr_syscr_tmo2");
    @(posedge pclk); #1 pend = 1'b1;
    repeat (3) @(posedge pclk);
    #3 preset_n = 1'b0;
    #4 pend = 1'b0;
    @(posedge pclk); #1 preset_n = 1'b1;
    apb_rd(8'h18, 32'hFF, 1'b0, "midrst_tmc");
    apb_rd(8'h10, 32'hFF, 1'b0, "midrst_tmo");
    apb_rd(8'h00, 32'h00, 1'b0, "midrst_syscr");
    apb_rd(8'h20, 32'h00, 1'b0, "midrst_ipr0");
    chk(2, 32'h0, "midrst_prio");

    repeat (5) @(posedge pclk);
    #1 do_final = 1'b1;
    @(negedge pclk); #1 do_final = 1'b0;
    @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
